// File: rtl/shared_reg_arb_pkg.sv
// Shared definitions for the shared-register arbiter: FSM state encoding,
// default sizing constants and the round-robin next-index search.
// Imported by shared_reg_arb and shared_reg_bank.
package shared_reg_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int NREQ_MAX  = 8;

  // First set bit of req searching upward from last+1, wrapping modulo n.
  // req is zero-extended to NREQ_MAX bits by the caller; n is the live
  // requester count. Returns 0 when no bit is set (caller gates on |req).
  function automatic logic [2:0] next_idx(input logic [NREQ_MAX-1:0] req,
                                          input logic [2:0]          last,
                                          input int unsigned         n);
    logic        found;
    logic [2:0]  idx;
    int unsigned cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int unsigned k = 1; k <= NREQ_MAX; k++) begin
      if (k <= n) begin
        cand = (32'(last) + k) % n;
        if (!found && req[cand[2:0]]) begin
          found = 1'b1;
          idx   = cand[2:0];
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/shared_reg_bank.sv
// Shared flop bank: W-bit register with write enable, synchronous active-low reset to 0.
// Ports: clk, rst_n, we (write strobe), d (write data), q (stored value).
// Holds its value whenever we is low.
module shared_reg_bank
  import shared_reg_arb_pkg::*;
#(
  parameter int W = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (we) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shared_reg_arb.sv
// Round-robin arbiter + write sequencer sharing one WIDTH-bit register among NREQ requesters.
// Ports: clk/rst_n (sync active-low), req/wdata in; gnt (one-hot, registered), q, upd, owner out.
// Optional macro SHARED_REG_ARB_PARITY_EN adds q_par (even parity of q, stored alongside q).
module shared_reg_arb
  import shared_reg_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        q,
  output logic                    upd,
  output logic [$clog2(NREQ)-1:0] owner
`ifdef SHARED_REG_ARB_PARITY_EN
  ,
  output logic                    q_par
`endif
);

  localparam int IW = $clog2(NREQ);
`ifdef SHARED_REG_ARB_PARITY_EN
  localparam int BW = WIDTH + 1;
`else
  localparam int BW = WIDTH;
`endif

  state_t          state_d, state_q;
  logic [NREQ-1:0] gnt_d,   gnt_q;
  logic [IW-1:0]   last_d,  last_q;
  logic [IW-1:0]   owner_d, owner_q;
  logic            upd_d,   upd_q;

  logic [NREQ_MAX-1:0] req_ext;
  logic [IW-1:0]       nxt;
  logic [WIDTH-1:0]    wsel;
  logic                bank_we;
  logic [BW-1:0]       bank_d;
  logic [BW-1:0]       bank_q;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
  end

  assign nxt = IW'(next_idx(req_ext, 3'(last_q), NREQ));

  // last_q doubles as the granted index while in GRANT, since it is
  // loaded with the winner on entry.
  assign wsel = wdata[int'(last_q)*WIDTH +: WIDTH];

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    last_d  = last_q;
    owner_d = owner_q;
    upd_d   = 1'b0;
    bank_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d     = ST_GRANT;
          last_d      = nxt;
          gnt_d[nxt]  = 1'b1;
        end
      end
      ST_GRANT: begin
        // Write regardless of whether the winner still holds req.
        state_d = ST_IDLE;
        bank_we = 1'b1;
        owner_d = last_q;
        upd_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      upd_q   <= upd_d;
    end
  end

`ifdef SHARED_REG_ARB_PARITY_EN
  assign bank_d = {^wsel, wsel};
`else
  assign bank_d = wsel;
`endif

  shared_reg_bank #(.W(BW)) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we),
    .d     (bank_d),
    .q     (bank_q)
  );

  assign q     = bank_q[WIDTH-1:0];
  assign gnt   = gnt_q;
  assign upd   = upd_q;
  assign owner = owner_q;
`ifdef SHARED_REG_ARB_PARITY_EN
  assign q_par = bank_q[WIDTH];
`endif

endmodule
